// File: rtl/solver_sched_pkg.sv
// Shared types and constants for the Solver job scheduler.
// Work codes match the Solver's work_2 encoding.
package solver_sched_pkg;

    localparam int RAW_WIDTH = 60;
    localparam int ENC_WIDTH = 78;

    localparam logic [1:0] WORK_ENC    = 2'd0;
    localparam logic [1:0] WORK_DEC    = 2'd1;
    localparam logic [1:0] WORK_REPLAY = 2'd2;
    localparam logic [1:0] WORK_NOP    = 2'd3;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
    typedef enum logic [1:0] {ENC, DEC, REPLAY} job_e;

    function automatic logic [1:0] work_code(input job_e kind);
        case (kind)
            ENC:     return WORK_ENC;
            DEC:     return WORK_DEC;
            REPLAY:  return WORK_REPLAY;
            default: return WORK_NOP;
        endcase
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; index 0 = encrypt client, 1 = decrypt client.
// Grant is combinational from req_i; last-grant updates only on accept_i.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       accept_i,
    output logic [1:0] grant_o
);

    // last_q = 1 means the decrypt client was served most recently
    logic last_q;

    always_comb begin
        grant_o = 2'b00;
        case (req_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = last_q ? 2'b01 : 2'b10;
            default: grant_o = 2'b00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else if (accept_i) begin
            last_q <= grant_o[1];
        end
    end

endmodule

// File: rtl/solver_scheduler.sv
// Arbitrates encrypt/decrypt/replay jobs onto the shared Solver datapath, one job in flight.
// Holds Solver inputs stable for the fixed latency, then returns the result on a valid/ready channel.
module solver_scheduler
    import solver_sched_pkg::*;
#(
    parameter int RAW_W   = RAW_WIDTH,
    parameter int ENC_W   = ENC_WIDTH,
    parameter int ENC_LAT = 3,
    parameter int DEC_LAT = 2
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             enc_req_valid,
    output logic             enc_req_ready,
    input  logic [RAW_W-1:0] enc_req_data,
    input  logic             dec_req_valid,
    output logic             dec_req_ready,
    input  logic [ENC_W-1:0] dec_req_data,
    input  logic             dec_req_replay,
    output logic             enc_rsp_valid,
    input  logic             enc_rsp_ready,
    output logic [ENC_W-1:0] enc_rsp_data,
    output logic             dec_rsp_valid,
    input  logic             dec_rsp_ready,
    output logic [RAW_W-1:0] dec_rsp_data,
    output logic [1:0]       sol_work,
    output logic [RAW_W-1:0] sol_data_raw,
    output logic [ENC_W-1:0] sol_data_enc,
    input  logic [ENC_W-1:0] sol_out_enc,
    input  logic [RAW_W-1:0] sol_out_raw,
    output logic             busy,
    output logic [15:0]      enc_count,
    output logic [15:0]      dec_count
);

    localparam int LAT_MAX = (ENC_LAT > DEC_LAT) ? ENC_LAT : DEC_LAT;
    localparam int CNT_W   = (LAT_MAX > 2) ? $clog2(LAT_MAX) : 1;

    state_e           state_q;
    job_e             kind_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       sol_work_q;
    logic [RAW_W-1:0] sol_raw_q;
    logic [ENC_W-1:0] sol_enc_q;
    logic [ENC_W-1:0] rsp_enc_q;
    logic [RAW_W-1:0] rsp_raw_q;
    logic [15:0]      enc_count_q;
    logic [15:0]      dec_count_q;
    logic [15:0]      enc_count_d;
    logic [15:0]      dec_count_d;

    logic [1:0] grant;
    logic       idle;
    logic       enc_hs;
    logic       dec_hs;
    logic       rsp_hs;

    rr_arbiter2 u_arb (
        .clk      (Clk),
        .rst      (Rst),
        .req_i    ({dec_req_valid, enc_req_valid}),
        .accept_i (enc_hs | dec_hs),
        .grant_o  (grant)
    );

    // Readies are a function of valids and state only, never of another ready
    assign idle          = (state_q == IDLE);
    assign enc_req_ready = idle & grant[0];
    assign dec_req_ready = idle & grant[1];
    assign enc_hs        = enc_req_valid & enc_req_ready;
    assign dec_hs        = dec_req_valid & dec_req_ready;

    assign enc_rsp_valid = (state_q == RESP) & (kind_q == ENC);
    assign dec_rsp_valid = (state_q == RESP) & (kind_q != ENC);
    assign rsp_hs        = (enc_rsp_valid & enc_rsp_ready) | (dec_rsp_valid & dec_rsp_ready);

    assign enc_count_d = enc_count_q + 16'd1;
    assign dec_count_d = dec_count_q + 16'd1;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= IDLE;
            kind_q      <= ENC;
            cnt_q       <= '0;
            sol_work_q  <= WORK_NOP;
            sol_raw_q   <= '0;
            sol_enc_q   <= '0;
            rsp_enc_q   <= '0;
            rsp_raw_q   <= '0;
            enc_count_q <= '0;
            dec_count_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (enc_hs) begin
                        kind_q     <= ENC;
                        sol_raw_q  <= enc_req_data;
                        sol_work_q <= WORK_ENC;
                        state_q    <= ISSUE;
                    end else if (dec_hs) begin
                        // Replay reuses the word already on the Solver's encrypted input
                        kind_q     <= dec_req_replay ? REPLAY : DEC;
                        sol_work_q <= work_code(dec_req_replay ? REPLAY : DEC);
                        if (!dec_req_replay) begin
                            sol_enc_q <= dec_req_data;
                        end
                        state_q    <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt_q   <= (kind_q == ENC) ? CNT_W'(ENC_LAT - 1) : CNT_W'(DEC_LAT - 1);
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        if (kind_q == ENC) begin
                            rsp_enc_q <= sol_out_enc;
                        end else begin
                            rsp_raw_q <= sol_out_raw;
                        end
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_hs) begin
                        if (kind_q == ENC) begin
                            enc_count_q <= enc_count_d;
                        end else begin
                            dec_count_q <= dec_count_d;
                        end
                        sol_work_q <= WORK_NOP;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sol_work     = sol_work_q;
    assign sol_data_raw = sol_raw_q;
    assign sol_data_enc = sol_enc_q;
    assign enc_rsp_data = rsp_enc_q;
    assign dec_rsp_data = rsp_raw_q;
    assign busy         = ~idle;
    assign enc_count    = enc_count_q;
    assign dec_count    = dec_count_q;

endmodule

// File: doc/solver_scheduler.md
# solver_scheduler

Sequences the shared `Solver` encrypt/decrypt datapath between two requesters: an encryption client (60-bit raw words) and a decryption client (78-bit encrypted words, plus replay of the last decrypted word). The block arbitrates round-robin and drives `Solver`'s `work_2`/data inputs stable for the datapath's fixed latency. It captures the result and returns it on the owning requester's valid/ready response channel. It sits between the system command interface and `Solver`; `Solver` itself is not modified.

## Interface
- `RAW_W`, 60, raw (plaintext) word width.
- `ENC_W`, 78, encrypted word width.
- `ENC_LAT`, 3, `Solver` cycles from stable inputs to valid `output_1_96`.
- `DEC_LAT`, 2, `Solver` cycles from stable inputs to valid `output_2_80` (also used for replay).
- `Clk` in 1: single clock, rising edge.
- `Rst` in 1: synchronous, active-high reset.
- `enc_req_valid` in 1, `enc_req_ready` out 1, `enc_req_data` in RAW_W: encryption request channel.
- `dec_req_valid` in 1, `dec_req_ready` out 1, `dec_req_data` in ENC_W: decryption request channel.
- `dec_req_replay` in 1: qualifies the decryption request; 1 means replay (`work_2`=2) and `dec_req_data` is ignored.
- `enc_rsp_valid` out 1, `enc_rsp_ready` in 1, `enc_rsp_data` out ENC_W: encryption response channel.
- `dec_rsp_valid` out 1, `dec_rsp_ready` in 1, `dec_rsp_data` out RAW_W: decryption response channel.
- `sol_work` out 2: to `Solver.work_2`.
- `sol_data_raw` out RAW_W: to `Solver.data_1_80`.
- `sol_data_enc` out ENC_W: to `Solver.data_2_96`.
- `sol_out_enc` in ENC_W: from `Solver.output_1_96`.
- `sol_out_raw` in RAW_W: from `Solver.output_2_80`.
- `busy` out 1: high in any state except IDLE.
- `enc_count`, `dec_count` out 16: completed-job counters. Replays count in `dec_count`.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: `sol_work`=3 (NOP), data outputs hold their last values. The round-robin grant is computed from the two request valids:
  - Only one requester valid: that requester is granted.
  - Both valid: the requester not served last is granted.
  - Ready is asserted only to the granted requester and only in IDLE.
  - Ready depends combinationally on valid. Ready must not depend on ready.
- Handshake (valid & ready at an edge):
  - Latch the job kind (ENC, DEC or REPLAY) and the data into the `sol_*` registers.
  - Update `last_grant`.
  - Move to ISSUE.
- ISSUE (1 cycle):
  - Present `sol_work` = 0 (ENC), 1 (DEC) or 2 (REPLAY).
  - Load `cnt` with the job's latency minus 1.
  - Move to WAIT.
- WAIT:
  - `cnt` decrements each cycle. `sol_*` outputs stay unchanged.
  - When `cnt`=0: capture `sol_out_enc` (ENC) or `sol_out_raw` (DEC/REPLAY) into the response register, then move to RESP.
- RESP:
  - The owning response valid is high and the data is stable.
  - On the rsp valid & ready edge: increment the owning counter (wraps 0xFFFF→0), go to IDLE, drop `sol_work` to 3.
  - Backpressure: RESP holds indefinitely and no new request is accepted. Only one job is ever in flight.
- A request valid that drops before its handshake is simply not served. Data is sampled only at the handshake.
- Reset, including mid-job:
  - Next state IDLE; any in-flight job is discarded with no response.
  - All valids and readies 0, `busy` 0, `sol_work`=3, `sol_*` data 0, response data 0, counters 0.
  - `last_grant`=DEC, so ENC wins the first contention after reset.

## Timing
- Handshake at edge T. ISSUE is cycle T+1. `sol_*` inputs are stable from T+1 until leaving RESP.
- ENC: capture at edge T+1+ENC_LAT. `enc_rsp_valid` is high from T+2+ENC_LAT (T+5 with defaults).
- DEC/REPLAY: `dec_rsp_valid` is high from T+2+DEC_LAT (T+4 with defaults).
- Response ready held high: rsp handshake at the first RESP edge, IDLE the next cycle. The next request handshake can happen in that IDLE cycle.
- Minimum request spacing with defaults and rsp ready high: ENC 6 cycles, DEC 5 cycles.

## Structure
- Package `solver_sched_pkg` holds:
  - Work codes WORK_ENC=0, WORK_DEC=1, WORK_REPLAY=2, WORK_NOP=3.
  - The state enum {IDLE, ISSUE, WAIT, RESP}.
  - The job-kind enum {ENC, DEC, REPLAY}.
  - Width constants 60/78.
- Sub-module `rr_arbiter2`: 2-input round-robin arbiter with grant and last-grant register, updated on an `accept` pulse.
- The FSM, latency counter and response registers live in `solver_scheduler`.

## Test plan
- Single ENC, rsp ready high: `enc_req_data`=60'h0123456789ABCDE handshake at T → `sol_work`=0 from T+1, `enc_rsp_valid` at T+5 with `enc_rsp_data` equal to the golden `Solver` output; `enc_count`=1.
- Single DEC then REPLAY: DEC word X → `dec_rsp_valid` at T+4 with decrypt(X). Then replay → `sol_work`=2, `dec_rsp_data` equal to the same decrypted value; `dec_count`=2.
- Contention: both valid continuously for 4 jobs after reset → grant order ENC, DEC, ENC, DEC; no two jobs overlap (`busy` never drops between grant and response).
- Backpressure: hold `enc_rsp_ready`=0 for 10 cycles after valid → valid and data stable, both req readies 0, `sol_*` unchanged; release → IDLE the next cycle.
- Reset mid-WAIT: assert `Rst` in WAIT of an ENC job → next cycle IDLE, `enc_rsp_valid`=0, counters 0, `sol_work`=3. The next contended request goes to ENC.
- Counter wrap: 65536 ENC jobs (or force preload to 0xFFFF) → `enc_count` wraps to 0 and `dec_count` is unaffected.
